// File: rtl/jtag_scan_master.sv
// jtag_scan_master
// Host-side JTAG TAP driver. It generates TCK/TMS/TDI, samples TDO, and walks
// the 1149.1 TAP controller through one IR or DR scan per command.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   cmd_valid/ready     command handshake (ready only while parked in RTI)
//   cmd_is_ir           1 = IR scan, 0 = DR scan
//   cmd_len             bits to shift (1..MAX_LEN; anything else is an error)
//   cmd_data            TDI bits, LSB shifted first
//   cmd_tlr             (only with JTAG_SCAN_RESET_CMD_EN) rerun the TLR sequence
//   rsp_valid/ready     response handshake
//   rsp_data            captured TDO bits, bit i from shift step i, upper bits 0
//   rsp_err             command length was illegal
//   busy                TLR sequence or scan in progress
//   tck, tms, tdi, tdo  JTAG pins (tdo already synchronised)
//
// Optional feature macro: JTAG_SCAN_RESET_CMD_EN adds the cmd_tlr input.
//
// Every TCK step is DIV_HALF clk with tck low, then DIV_HALF clk with tck high.
// tms/tdi change on the clk where tck falls; tdo is sampled where tck rises.
module jtag_scan_master #(
  parameter int DIV_HALF = 2,
  parameter int MAX_LEN  = 64,
  parameter int LEN_W    = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_is_ir,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
`ifdef JTAG_SCAN_RESET_CMD_EN
  input  logic               cmd_tlr,
`endif
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               rsp_err,
  output logic               busy,
  output logic               tck,
  output logic               tms,
  output logic               tdi,
  input  logic               tdo
);

  localparam int          DIV_W     = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
  localparam int          IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int          TLR_ONES  = 5;
  localparam logic [31:0] MAX_LEN_U = 32'(MAX_LEN);

  // Each stepping state names the TCK step currently being driven:
  //   SEL_DR  : RTI -> Select-DR (tms=1)
  //   SEL_IR  : Select-DR -> Select-IR (tms=1, IR scans only)
  //   CAPTURE : Select -> Capture (tms=0)
  //   SHIFT   : Capture -> Shift (entry step, tms=0), then the len shift steps
  //   EXIT1   : Exit1 -> Update (tms=1)
  //   UPDATE  : Update -> RTI (tms=0)
  typedef enum logic [3:0] {
    TLR_SEQ, IDLE, SEL_DR, SEL_IR, CAPTURE, SHIFT, EXIT1, UPDATE, RESP
  } state_t;

  state_t             state_reg;
  logic [DIV_W-1:0]   div_cnt_reg;
  logic [LEN_W-1:0]   bit_cnt_reg;
  logic [LEN_W-1:0]   len_reg;
  logic [MAX_LEN-1:0] data_reg;
  logic               is_ir_reg;
  logic               entry_reg;    // SHIFT is still on its Capture->Shift step
  logic               tlr_rsp_reg;  // TLR_SEQ was started by a command, so respond

  logic               tlr_cmd;
`ifdef JTAG_SCAN_RESET_CMD_EN
  assign tlr_cmd = cmd_tlr;
`else
  assign tlr_cmd = 1'b0;
`endif

  logic               div_done;
  logic               bad_len;
  logic               last_bit;
  logic [LEN_W-1:0]   bit_nxt;
  logic [IDX_W-1:0]   cur_idx;
  logic [IDX_W-1:0]   nxt_idx;

  assign div_done = (div_cnt_reg == DIV_W'(DIV_HALF - 1));
  assign bad_len  = (cmd_len == '0) || (32'(cmd_len) > MAX_LEN_U);
  assign last_bit = (bit_cnt_reg == len_reg - 1'b1);
  assign bit_nxt  = bit_cnt_reg + 1'b1;
  // bit_cnt never exceeds len-1 < MAX_LEN, so the low bits are a safe index.
  assign cur_idx  = bit_cnt_reg[IDX_W-1:0];
  assign nxt_idx  = bit_nxt[IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= TLR_SEQ;
      div_cnt_reg <= '0;
      bit_cnt_reg <= '0;
      len_reg     <= '0;
      data_reg    <= '0;
      is_ir_reg   <= 1'b0;
      entry_reg   <= 1'b0;
      tlr_rsp_reg <= 1'b0;
      tck         <= 1'b0;
      tms         <= 1'b1;
      tdi         <= 1'b0;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
      busy        <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready   <= 1'b0;
            busy        <= 1'b1;
            rsp_data    <= '0;
            div_cnt_reg <= '0;
            bit_cnt_reg <= '0;
            is_ir_reg   <= cmd_is_ir;
            len_reg     <= cmd_len;
            data_reg    <= cmd_data;
            if (tlr_cmd) begin
              state_reg   <= TLR_SEQ;
              tms         <= 1'b1;
              tlr_rsp_reg <= 1'b1;
              rsp_err     <= 1'b0;
            end else if (bad_len) begin
              state_reg <= RESP;
              rsp_err   <= 1'b1;
            end else begin
              // The accept edge also launches the first step (RTI -> Select-DR).
              state_reg <= SEL_DR;
              tms       <= 1'b1;
              rsp_err   <= 1'b0;
            end
          end
        end

        RESP: begin
          // Entered on the clk where tck fell for the last time; valid follows.
          if (!rsp_valid) begin
            rsp_valid <= 1'b1;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            state_reg <= IDLE;
          end
        end

        default: begin
          if (!div_done) begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
          end else if (!tck) begin
            div_cnt_reg <= '0;
            tck         <= 1'b1;
            if (state_reg == SHIFT && !entry_reg) rsp_data[cur_idx] <= tdo;
          end else begin
            // Step boundary: tck falls and the next step's tms/tdi go out.
            div_cnt_reg <= '0;
            tck         <= 1'b0;
            case (state_reg)
              TLR_SEQ: begin
                if (bit_cnt_reg == LEN_W'(TLR_ONES)) begin
                  bit_cnt_reg <= '0;
                  if (tlr_rsp_reg) begin
                    tlr_rsp_reg <= 1'b0;
                    state_reg   <= RESP;
                  end else begin
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                  end
                end else begin
                  bit_cnt_reg <= bit_nxt;
                  tms         <= (bit_nxt < LEN_W'(TLR_ONES));
                end
              end
              SEL_DR: begin
                state_reg <= is_ir_reg ? SEL_IR : CAPTURE;
                tms       <= is_ir_reg;
              end
              SEL_IR: begin
                state_reg <= CAPTURE;
                tms       <= 1'b0;
              end
              CAPTURE: begin
                state_reg <= SHIFT;
                entry_reg <= 1'b1;
                tms       <= 1'b0;
              end
              SHIFT: begin
                if (entry_reg) begin
                  entry_reg   <= 1'b0;
                  bit_cnt_reg <= '0;
                  tms         <= (len_reg == LEN_W'(1));
                  tdi         <= data_reg[0];
                end else if (last_bit) begin
                  state_reg <= EXIT1;
                  tms       <= 1'b1;
                  tdi       <= 1'b0;
                end else begin
                  bit_cnt_reg <= bit_nxt;
                  tms         <= (bit_nxt == len_reg - 1'b1);
                  tdi         <= data_reg[nxt_idx];
                end
              end
              EXIT1: begin
                state_reg <= UPDATE;
                tms       <= 1'b0;
              end
              UPDATE: begin
                state_reg <= RESP;
              end
              default: begin
                state_reg <= TLR_SEQ;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_scan_master.sv
// tb_jtag_scan_master
// Directed and randomised scans against jtag_scan_master, with expected TMS
// sequences, TDI bits and responses computed from the TAP scan rules.
module tb_jtag_scan_master;

  localparam int DIV_HALF = 2;
  localparam int MAX_LEN  = 64;
  localparam int LEN_W    = 7;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic               cmd_is_ir = 1'b0;
  logic [LEN_W-1:0]   cmd_len = '0;
  logic [MAX_LEN-1:0] cmd_data = '0;
`ifdef JTAG_SCAN_RESET_CMD_EN
  logic               cmd_tlr = 1'b0;
`endif
  logic               rsp_valid;
  logic               rsp_ready = 1'b1;
  logic [MAX_LEN-1:0] rsp_data;
  logic               rsp_err;
  logic               busy;
  logic               tck;
  logic               tms;
  logic               tdi;
  logic               tdo;

  int checks = 0;
  int failures = 0;

  // tdo source: 0 = loop back tdi, 1 = constant, 2 = new random bit each step
  int   tdo_mode = 0;
  logic tdo_const = 1'b0;
  logic tdo_rand = 1'b0;
  assign tdo = (tdo_mode == 0) ? tdi : (tdo_mode == 1) ? tdo_const : tdo_rand;

  bit tms_q[$];
  bit tdi_q[$];
  bit tdo_q[$];
  int rsp_cnt = 0;

  always #5 clk = ~clk;

  always @(negedge tck) tdo_rand <= 1'($urandom);

  always @(posedge tck) begin
    tms_q.push_back(tms);
    tdi_q.push_back(tdi);
    tdo_q.push_back(tdo);
  end

  always @(posedge clk) if (rsp_valid) rsp_cnt <= rsp_cnt + 1;

  jtag_scan_master #(.DIV_HALF(DIV_HALF), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_is_ir(cmd_is_ir),
    .cmd_len(cmd_len), .cmd_data(cmd_data),
`ifdef JTAG_SCAN_RESET_CMD_EN
    .cmd_tlr(cmd_tlr),
`endif
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy), .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_tck"}, tck, 0);
    chk({tag, "_tms"}, tms, 1);
    chk({tag, "_tdi"}, tdi, 0);
    chk({tag, "_cmd_ready"}, cmd_ready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
    chk({tag, "_busy"}, busy, 1);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready_timeout"}, cmd_ready, 1);
  endtask

  // TMS recorded from index base must be the TLR pattern 1,1,1,1,1,0.
  task automatic chk_tlr(input string tag, input int base);
    logic [127:0] v = '0;
    int n = tms_q.size() - base;
    for (int k = 0; k < n && k < 128; k++) v[k] = tms_q[base + k];
    chk({tag, "_tlr_steps"}, n, 6);
    chk({tag, "_tlr_tms"}, v, 128'h1F);
    chk({tag, "_idle_busy"}, busy, 0);
  endtask

  task automatic issue(input bit ir, input int len, input logic [63:0] data);
    cmd_valid = 1'b1;
    cmd_is_ir = ir;
    cmd_len   = LEN_W'(len);
    cmd_data  = data;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // One legal scan: model the TMS/TDI/TDO rules, then compare everything.
  task automatic run_scan(input string tag, input bit ir, input int len,
                          input logic [63:0] data, input int mode, input bit cval,
                          input bit hold);
    bit           exp_tms[$];
    logic [127:0] ev, ov;
    logic [63:0]  exp_rsp, obs_tdi, exp_tdi;
    int           base, first, n, rcnt;
    wait_ready(tag);
    tdo_mode  = mode;
    tdo_const = cval;
    rsp_ready = !hold;
    base = tms_q.size();
    issue(ir, len, data);
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_cmd_ready_low"}, cmd_ready, 0);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_rsp_timeout"}, rsp_valid, 1);

    exp_tms.push_back(1'b1);
    if (ir) exp_tms.push_back(1'b1);
    exp_tms.push_back(1'b0);
    exp_tms.push_back(1'b0);
    first = exp_tms.size();
    for (int i = 0; i < len; i++) exp_tms.push_back(i == len - 1);
    exp_tms.push_back(1'b1);
    exp_tms.push_back(1'b0);

    ev = '0;
    ov = '0;
    for (int k = 0; k < exp_tms.size(); k++) ev[k] = exp_tms[k];
    for (int k = 0; k < tms_q.size() - base && k < 128; k++) ov[k] = tms_q[base + k];
    exp_rsp = '0;
    obs_tdi = '0;
    exp_tdi = '0;
    for (int i = 0; i < len; i++) begin
      exp_tdi[i] = data[i];
      if (base + first + i < tdi_q.size()) begin
        obs_tdi[i] = tdi_q[base + first + i];
        exp_rsp[i] = (mode == 0) ? data[i] : (mode == 1) ? cval : tdo_q[base + first + i];
      end
    end
    chk({tag, "_steps"}, tms_q.size() - base, exp_tms.size());
    chk({tag, "_tms_seq"}, ov, ev);
    chk({tag, "_tdi_seq"}, obs_tdi, exp_tdi);
    chk({tag, "_rsp_data"}, rsp_data, exp_rsp);
    chk({tag, "_rsp_err"}, rsp_err, 0);
    chk({tag, "_tck_rest"}, tck, 0);

    if (hold) begin
      for (int c = 0; c < 20; c++) begin
        if (c == 5) begin
          cmd_valid = 1'b1;
          cmd_len   = LEN_W'(8);
          cmd_data  = 64'h3C;
        end else begin
          cmd_valid = 1'b0;
        end
        @(negedge clk);
        chk({tag, "_hold_valid"}, rsp_valid, 1);
        chk({tag, "_hold_data"}, rsp_data, exp_rsp);
        chk({tag, "_hold_cmd_ready"}, cmd_ready, 0);
      end
      rsp_ready = 1'b1;
    end
    @(negedge clk);
    chk({tag, "_rsp_released"}, rsp_valid, 0);
    chk({tag, "_cmd_ready_back"}, cmd_ready, 1);
    if (hold) begin
      base = tms_q.size();
      rcnt = rsp_cnt;
      repeat (30) @(negedge clk);
      chk({tag, "_ignored_steps"}, tms_q.size() - base, 0);
      chk({tag, "_ignored_rsp"}, rsp_cnt - rcnt, 0);
    end
    $display("scan %s ir=%0d len=%0d data=%h mode=%0d rsp=%h", tag, ir, len, data, mode, rsp_data);
  endtask

  task automatic run_bad(input string tag, input int len);
    int base, n;
    wait_ready(tag);
    rsp_ready = 1'b1;
    base = tms_q.size();
    issue(1'b0, len, 64'hFFFF_FFFF_FFFF_FFFF);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency_ok"}, (rsp_valid === 1'b1) && (n <= 2), 1);
    chk({tag, "_rsp_err"}, rsp_err, 1);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    chk({tag, "_no_tck"}, tms_q.size() - base, 0);
    @(negedge clk);
    chk({tag, "_cmd_ready_back"}, cmd_ready, 1);
    $display("bad %s len=%0d err=%0d", tag, len, rsp_err);
  endtask

  initial begin
    int base, rcnt, n;
    logic [63:0] rd;

    // Reset state and the TLR walk into RTI.
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    base = tms_q.size();
    reset = 1'b0;
    wait_ready("boot");
    chk_tlr("boot", base);
    base = tms_q.size();
    repeat (10) begin
      @(negedge clk);
      chk("idle_tck_low", tck, 0);
    end
    chk("idle_no_steps", tms_q.size() - base, 0);
    $display("boot tlr steps done, cmd_ready=%0d", cmd_ready);

    // Directed scans from the plan.
    run_scan("dr_a5", 1'b0, 8, 64'hA5, 0, 1'b0, 1'b0);
    run_scan("ir_2", 1'b1, 2, 64'h2, 1, 1'b1, 1'b0);
    run_scan("dr_len1", 1'b0, 1, 64'h1, 0, 1'b0, 1'b0);
    run_scan("dr_len64", 1'b0, 64, {$urandom, $urandom}, 2, 1'b0, 1'b0);

    // Illegal lengths.
    run_bad("len0", 0);
    run_bad("len65", 65);

    // Response held off; a cmd_valid pulse meanwhile must be dropped.
    run_scan("hold", 1'b0, 12, {$urandom, $urandom}, 2, 1'b0, 1'b1);

    // Random scans.
    for (int t = 0; t < 8; t++) begin
      run_scan($sformatf("rand%0d", t), 1'($urandom), $urandom_range(1, MAX_LEN),
               {$urandom, $urandom}, $urandom_range(0, 2), 1'($urandom), 1'b0);
    end

    // Reset while shifting bit 30 of a 64-bit DR scan.
    wait_ready("mid");
    tdo_mode = 0;
    rsp_ready = 1'b1;
    rcnt = rsp_cnt;
    base = tms_q.size();
    rd = {$urandom, $urandom};
    issue(1'b0, 64, rd);
    n = 0;
    while (tms_q.size() - base < 34 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("mid_reached_bit30", tms_q.size() - base, 34);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_vals("mid_reset");
    base = tms_q.size();
    reset = 1'b0;
    wait_ready("mid_tlr");
    chk_tlr("mid", base);
    chk("mid_no_rsp", rsp_cnt - rcnt, 0);
    $display("mid-scan reset recovered, rsp count delta=%0d", rsp_cnt - rcnt);

`ifdef JTAG_SCAN_RESET_CMD_EN
    wait_ready("tlrcmd");
    base = tms_q.size();
    cmd_tlr = 1'b1;
    issue(1'b1, 0, 64'hFF);
    cmd_tlr = 1'b0;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("tlrcmd_rsp", rsp_valid, 1);
    chk("tlrcmd_err", rsp_err, 0);
    chk("tlrcmd_data", rsp_data, 0);
    chk("tlrcmd_steps", tms_q.size() - base, 6);
    @(negedge clk);
    $display("tlr command done");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jtag_scan_master.md
Name: jtag_scan_master

Overview:
- Host-side JTAG TAP driver for the debug path: the initiator that generates TCK/TMS/TDI and samples TDO.
- Walks the IEEE 1149.1 TAP state machine to perform one IR or DR scan per command.
- Sits on the system clock domain; bit-bangs a board or virtual JTAG chain targeting the CPU debug module's TAP-side shift register.
- Used for on-chip bring-up and self-test of the debug path without an external cable.

Parameters:
- DIV_HALF, 2, clk cycles per TCK half-period (≥1); TCK = clk / (2*DIV_HALF).
- MAX_LEN, 64, maximum scan length in bits; also the width of cmd_data and rsp_data.
- LEN_W, 7, width of cmd_len.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  engine idle in Run-Test/Idle (RTI) and no response pending.
- cmd_is_ir  in  1  1 = IR scan, 0 = DR scan.
- cmd_len  in  LEN_W  number of bits to shift.
- cmd_data  in  MAX_LEN  TDI bits, LSB shifted first.
- rsp_valid  out  1  scan result available.
- rsp_ready  in  1  result consumed.
- rsp_data  out  MAX_LEN  captured TDO bits; bit i = TDO sampled during shift bit i; bits ≥ len are 0.
- rsp_err  out  1  command had illegal length.
- busy  out  1  TLR sequence or scan in progress.
- tck  out  1  JTAG clock.
- tms  out  1  JTAG mode select.
- tdi  out  1  JTAG data to target.
- tdo  in  1  JTAG data from target; pre-synchronised externally.

Behaviour:
- Reset values: tck=0, tms=1, tdi=0, cmd_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, busy=1.
- TCK step timing:
  - Each TCK step is DIV_HALF clk low, then DIV_HALF clk high.
  - tms and tdi update on the clk where tck goes low.
  - tdo is sampled on the clk where tck goes high (rising edge).
  - tck is held 0 when idle.
- States: TLR_SEQ, IDLE, SEL_DR, SEL_IR, CAPTURE, SHIFT, EXIT1, UPDATE, RESP.
- After reset:
  - TLR_SEQ issues 5 steps with tms=1, then 1 step with tms=0 to reach RTI.
  - Then enters IDLE; cmd_ready=1 and busy=0.
- Accept: a command is accepted on cmd_valid && cmd_ready. cmd_is_ir, cmd_len and cmd_data are latched, cmd_ready drops and busy rises on the next clk.
- Length checks: if cmd_len == 0 or cmd_len > MAX_LEN:
  - No TCK activity.
  - RESP is entered next clk with rsp_err=1 and rsp_data=0.
- DR scan TMS sequence from RTI: 1 (Select-DR), 0 (Capture-DR), 0 (Shift-DR), then len shift steps, then 1 (Update-DR), 0 (RTI).
  - Shift steps use tms=0 except the last, which uses tms=1 (Exit1-DR).
  - Total: len+5 TCK steps.
- IR scan: same sequence with an extra tms=1 step after Select-DR (Select-IR). Total: len+6 TCK steps.
- During shift step i: tdi = cmd_data[i]; the TDO sample goes to rsp_data[i].
- Completion:
  - rsp_valid asserts 1 clk after the falling-edge boundary that ends the final RTI step.
  - rsp_valid, rsp_data and rsp_err are held until rsp_valid && rsp_ready.
  - cmd_ready returns 1 the clk after the handshake.
- rsp_ready held high: the response is consumed in its first valid cycle, giving a minimum of 1 clk of rsp_valid.
- cmd_valid while busy: ignored; it is not queued.
- Reset mid-scan:
  - All outputs return to reset values and the in-flight command is discarded; no response is issued.
  - TLR_SEQ reruns.
- Counters:
  - Bit counter is LEN_W wide, counts 0..len-1, with no wrap past len-1.
  - Divider counter is sized for DIV_HALF-1.

Optional Feature:
- Macro: JTAG_SCAN_RESET_CMD_EN.
- With the macro defined:
  - Adds input cmd_tlr (1 bit).
  - A command accepted with cmd_tlr=1 ignores cmd_is_ir, cmd_len and cmd_data.
  - It reruns TLR_SEQ (5×tms=1 then tms=0), then issues a response with rsp_data=0 and rsp_err=0.
- Without the macro: the port is absent, and TLR_SEQ runs only after reset.

Test Plan:
- Reset then idle → exactly 6 TCK rising edges with tms=1,1,1,1,1,0; cmd_ready=1 afterwards; tck=0 while idle.
- DR scan, DIV_HALF=2, len=8, data=0xA5, tdo looped to tdi → 13 TCK steps; tdi sequence 1,0,1,0,0,1,0,1; rsp_data=0xA5; rsp_err=0.
- IR scan, len=2, data=2'b10, tdo tied 1 → TMS 1,1,0,0,0,1,1,0 (8 steps); rsp_data=0x3.
- cmd_len=0, then cmd_len=65 → no tck toggles; rsp_valid within 2 clk with rsp_err=1 and rsp_data=0.
- rsp_ready held 0 for 20 clk after completion → rsp_valid and rsp_data stable, cmd_ready=0; a cmd_valid pulse in this window is ignored.
- Reset asserted mid-shift at bit 30 of a 64-bit DR scan → outputs at reset values next clk; 6-step TLR sequence follows; no rsp_valid.
